rx_control: RTL

RX_CONTROL -- requirements
Module: rx_control

---
 rtl/rx_control.sv | 118 +++++++++++
 1 files changed

// File: rtl/rx_control.sv
// rx_control: decodes a byte stream from a UART receiver into operand loads,
// ALU op selection and send requests. Frames are command byte plus payload;
// a frame left idle for TIMEOUT cycles between bytes is aborted.
module rx_control #(
  parameter int unsigned TIMEOUT    = 1_000_000,
  parameter logic [7:0]  CMD_LOAD_A = 8'h01,
  parameter logic [7:0]  CMD_LOAD_B = 8'h02,
  parameter logic [7:0]  CMD_OP     = 8'h03,
  parameter logic [7:0]  CMD_SEND   = 8'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [1:0]  alu_ctrl,
  output logic        load_done,
  output logic        send_req,
  output logic        cmd_err,
  output logic        frame_err,
  output logic        frame_busy
);

  // Counter only ever needs to hold 0..TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LSB = 2'd1,
    WAIT_MSB = 2'd2,
    WAIT_OP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [7:0]    holding;
  logic          target_b;   // 1 = current load frame targets operand_b

  // Frame FSM with registered outputs; pulses default low every cycle.
  // NOTE: every register here is sequential state, so all assignments are
  // non-blocking; mixing blocking ones would make results order-dependent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      holding    <= '0;
      target_b   <= 1'b0;
      operand_a  <= '0;
      operand_b  <= '0;
      alu_ctrl   <= '0;
      load_done  <= 1'b0;
      send_req   <= 1'b0;
      cmd_err    <= 1'b0;
      frame_err  <= 1'b0;
      frame_busy <= 1'b0;
    end else begin
      load_done <= 1'b0;
      send_req  <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE) begin
        count <= '0;
        if (rx_ready) begin
          if (rx_data == CMD_LOAD_A || rx_data == CMD_LOAD_B) begin
            target_b   <= (rx_data != CMD_LOAD_A);
            state      <= WAIT_LSB;
            frame_busy <= 1'b1;
          end else if (rx_data == CMD_OP) begin
            state      <= WAIT_OP;
            frame_busy <= 1'b1;
          end else if (rx_data == CMD_SEND) begin
            send_req <= 1'b1;
          end else begin
            cmd_err <= 1'b1;
          end
        end
      end else if (rx_ready) begin
        // A strobe always wins over an expiring timeout.
        count <= '0;
        case (state)
          WAIT_LSB: begin
            holding <= rx_data;
            state   <= WAIT_MSB;
          end
          WAIT_MSB: begin
            if (target_b) operand_b <= {rx_data, holding};
            else          operand_a <= {rx_data, holding};
            load_done  <= 1'b1;
            state      <= IDLE;
            frame_busy <= 1'b0;
          end
          default: begin // WAIT_OP
            if (rx_data[7:2] == 6'd0) begin
              alu_ctrl  <= rx_data[1:0];
              load_done <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
            state      <= IDLE;
            frame_busy <= 1'b0;
          end
        endcase
      end else if (count == LAST) begin
        // TIMEOUT silent cycles: drop the partial frame.
        count      <= '0;
        frame_err  <= 1'b1;
        state      <= IDLE;
        frame_busy <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
